// File: rtl/conv_pkg.sv
// conv_pkg: shared window geometry for the sliding-window generator and the MAC core
package conv_pkg;
  localparam int KERNEL_SIZE = 3;
  localparam int WINDOW_NUM = KERNEL_SIZE * KERNEL_SIZE;
  localparam int DATA_WIDTH = 8;
  function automatic int win_idx(input int r, input int c);
    return KERNEL_SIZE * r + c;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image line, single address, read-before-write, distributed-RAM friendly
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int DATA_WIDTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign dout = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= din;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 valid-only window generator feeding the MAC core
module conv_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW_NUM = 9,
  parameter int MAX_WIDTH = 256,
  parameter int DIM_WIDTH = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            pixel_in,
  input  logic                             pixel_valid_in,
  input  logic                             frame_start_in,
  input  logic [DIM_WIDTH-1:0]             img_width_in,
  input  logic [DIM_WIDTH-1:0]             img_height_in,
  output logic [WINDOW_NUM*DATA_WIDTH-1:0] window_data_out,
  output logic                             window_valid_out,
  output logic                             frame_done_out
);
  import conv_pkg::*;
  localparam int AW = $clog2(MAX_WIDTH);
  logic [DIM_WIDTH-1:0] w_q, h_q, col, row;
  logic [DIM_WIDTH-1:0] cur_w, cur_h, cur_col, cur_row, col_nxt, row_nxt;
  logic [DATA_WIDTH-1:0] lb1_q, lb2_q;
  logic [WINDOW_NUM-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic eol, last, hit;
  // A frame start applies to a coincident pixel, so it sees (0,0) and the new dimensions
  always_comb begin
    cur_w = frame_start_in ? img_width_in : w_q;
    cur_h = frame_start_in ? img_height_in : h_q;
    cur_col = frame_start_in ? '0 : col;
    cur_row = frame_start_in ? '0 : row;
    eol = cur_col == cur_w - 1'b1;
    last = eol && cur_row == cur_h - 1'b1;
    hit = cur_row >= DIM_WIDTH'(2) && cur_col >= DIM_WIDTH'(2);
    col_nxt = eol ? '0 : cur_col + 1'b1;
    row_nxt = last ? '0 : eol ? cur_row + 1'b1 : cur_row;
    win_d = {pixel_in, win_q[8:7], lb1_q, win_q[5:4], lb2_q, win_q[2:1]};
  end
  line_buffer #(.DEPTH(MAX_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb1 (
    .clk(clk), .we(pixel_valid_in), .addr(cur_col[AW-1:0]), .din(pixel_in), .dout(lb1_q)
  );
  line_buffer #(.DEPTH(MAX_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb2 (
    .clk(clk), .we(pixel_valid_in), .addr(cur_col[AW-1:0]), .din(lb1_q), .dout(lb2_q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_q <= DIM_WIDTH'(KERNEL_SIZE);
      h_q <= DIM_WIDTH'(KERNEL_SIZE);
      col <= '0;
      row <= '0;
      win_q <= '0;
      window_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      window_valid_out <= pixel_valid_in && hit;
      frame_done_out <= pixel_valid_in && last;
      if (frame_start_in) begin
        w_q <= img_width_in;
        h_q <= img_height_in;
      end
      if (pixel_valid_in) begin
        col <= col_nxt;
        row <= row_nxt;
        win_q <= win_d;
      end else if (frame_start_in) begin
        col <= '0;
        row <= '0;
      end
    end
  assign window_data_out = win_q;
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator that sits directly upstream of the NPU MAC core. It accepts one 8-bit feature-map pixel per cycle in raster order and buffers the two previous rows in on-chip line buffers. For every pixel that completes a full 3x3 neighbourhood, it presents the nine pixels in parallel on a bus that drives the MAC core's 9-input data port (`MAC_data_in` / `MAC_data_valid_in`). Convolution is valid-only (no padding, stride 1), so a W x H frame yields (W-2)*(H-2) windows.

## Interface
Parameters:
- `DATA_WIDTH`, 8, pixel width.
- `WINDOW_NUM`, 9, pixels per window (3x3); matches the MAC core input count.
- `MAX_WIDTH`, 256, line-buffer depth; the largest supported image width.
- `DIM_WIDTH`, 9, width of the image-dimension inputs and the internal counters.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pixel_in`  in  DATA_WIDTH  input pixel in raster order.
- `pixel_valid_in`  in  1  `pixel_in` is accepted this cycle; there is no backpressure.
- `frame_start_in`  in  1  one-cycle pulse; restarts the counters and samples the image dimensions.
- `img_width_in`  in  DIM_WIDTH  frame width W; 3 ≤ W ≤ MAX_WIDTH.
- `img_height_in`  in  DIM_WIDTH  frame height H; H ≥ 3.
- `window_data_out`  out  WINDOW_NUM*DATA_WIDTH  3x3 window; slice k = 3*r + c, where r=0 is the top (oldest) row and c=0 is the left (oldest) column.
- `window_valid_out`  out  1  one-cycle strobe per window.
- `frame_done_out`  out  1  one-cycle pulse after the last pixel of the frame.

## Operation
- Dimensions are latched into `w_q` and `h_q` when `frame_start_in` is high. They are not re-sampled at any other time.
- Counters `col` (0..W-1) and `row` (0..H-1) advance only on an accepted pixel.
  - `col` wraps at `w_q`-1 and increments `row`.
  - At (`w_q`-1, `h_q`-1), both counters return to 0.
- On an accepted pixel at column `col`:
  - The new window column is {top=lb2[col], mid=lb1[col], bot=`pixel_in`}.
  - Line-buffer update: lb2[col] ← lb1[col], lb1[col] ← `pixel_in`. Line-buffer reads are read-before-write.
  - The 3x3 window register shifts left by one column. The new column enters at c=2.
- `window_valid_out` is registered high the next cycle iff the accepted pixel had `row` ≥ 2 and `col` ≥ 2, using the counter values before increment.
- `frame_done_out` is registered high the next cycle iff the accepted pixel was at (`w_q`-1, `h_q`-1).
- `frame_start_in` coincident with `pixel_valid_in`: that pixel is treated as (0,0) of the new frame, using the new dimensions.
- `frame_start_in` without a pixel: the counters go to 0 and the next accepted pixel is (0,0).
- `frame_start_in` mid-frame abandons the current frame. No `frame_done_out` is emitted for the abandoned frame.
- Idle cycles (`pixel_valid_in`=0): all state holds. Both strobes are 0.
- Line-buffer contents are never cleared. Stale data is never output, because gating on `row` ≥ 2 guarantees both lines were rewritten in the current frame.

## Timing
- Latency: 1 cycle from the accepting edge to `window_valid_out` / `window_data_out`.
- Throughput: one window per cycle at full pixel rate.
- `window_data_out` is held between strobes. Downstream samples it only when `window_valid_out` is high.
- Reset values: `window_data_out`=0, `window_valid_out`=0, `frame_done_out`=0.
- Reset clears the counters to (0,0), the window register to 0, and `w_q`/`h_q` to 3.
- Reset asserted mid-frame: outputs drop to 0 asynchronously. The first frame after reset requires `frame_start_in`.
- On the last pixel of a frame, `frame_done_out` and the final `window_valid_out` assert in the same cycle.

## Structure
- Shared package `conv_pkg` holds:
  - `KERNEL_SIZE`=3 and `WINDOW_NUM`=KERNEL_SIZE².
  - `DATA_WIDTH`.
  - The window slice-index convention (k = 3*r + c), shared with the MAC core.
- Sub-module `line_buffer`: one MAX_WIDTH x DATA_WIDTH line with a single address, read-before-write, and a write enable. It is instantiated twice and chained (lb1 feeds lb2). It is mappable to distributed RAM.

## Test plan
- W=H=4, pixels 0..15 sent back-to-back:
  - 4 windows are produced.
  - The first window appears one cycle after pixel 10 is accepted and equals {0,1,2,4,5,6,8,9,10}.
  - The last window is {5,6,7,9,10,11,13,14,15} and coincides with `frame_done_out`.
- Same frame with `pixel_valid_in` toggling every other cycle: identical window sequence. Strobes appear only after accepted pixels.
- W=5, H=3, pixels 0..14: exactly 3 windows.
  - First window is {0,1,2,5,6,7,10,11,12}; third is {2,3,4,7,8,9,12,13,14}.
  - No window is produced across the row wrap.
- Two back-to-back frames, 4x4 then 6x3, with `frame_start_in` coincident with each first pixel:
  - Windows are 4 then 4.
  - The second frame's windows contain only second-frame pixels.
- `frame_start_in` after 7 pixels of a 4x4 frame:
  - No `frame_done_out` for the abandoned frame.
  - The new frame yields exactly 4 correct windows.
- `rst` asserted for 2 cycles mid-window-stream:
  - `window_valid_out`=0 and `window_data_out`=0 immediately.
  - After `frame_start_in`, a 4x4 frame reproduces the first test's results.
